uncache_axi_bridge: RTL and testbench
=====================================

UNCACHE_AXI_BRIDGE -- requirements
Module: uncache_axi_bridge

Interface
REQ-001 Parameter AXI_ID, default 4'd1: fixed ID driven on arid/awid for uncached traffic.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 rd_req  input  1  uncached read request (cache side, master of AXI_UNCACHE_Interface).
REQ-005 rd_addr  input  32  physical read address.
REQ-006 rd_size  input  2  0=byte, 1=half, 2=word; derived from loadType by the instantiating wrapper.
REQ-007 rd_rdy  output  1  bridge accepts a read this cycle.
REQ-008 ret_valid  output  1  one-cycle pulse, ret_data valid.
REQ-009 ret_data  output  32  registered read data.
REQ-010 wr_req / wr_addr / wr_data / wr_wstrb  input  1/32/32/4  uncached write request, address, data, byte strobes.
REQ-011 wr_rdy  output  1  bridge accepts a write this cycle.
REQ-012 wr_valid  output  1  one-cycle pulse, write response received.
REQ-013 arid, araddr, arsize, arvalid  output  4/32/3/1  AXI read address channel; arready input 1.
REQ-014 rdata, rresp, rlast, rvalid  input  32/2/1/1  AXI read data channel; rready output 1.
REQ-015 awid, awaddr, awsize, awvalid  output  4/32/3/1  AXI write address channel; awready input 1.
REQ-016 wdata, wstrb, wlast, wvalid  output  32/4/1/1  AXI write data channel; wready input 1.
REQ-017 bresp, bvalid  input  2/1  AXI write response; bready output 1.
REQ-018 arlen, awlen  output  8 each  constant 0; arburst, awburst output 2 each, constant 2'b01; wlast constant 1.

Function
REQ-019 Read FSM states R_IDLE, R_AR, R_R, R_RET; write FSM states W_IDLE, W_REQ, W_B, W_RET.
REQ-020 rd_rdy = (R_IDLE && W_IDLE); wr_rdy = (R_IDLE && W_IDLE); at most one uncached transaction outstanding.
REQ-021 rd_req && wr_req both high while idle: write accepted, read not accepted (rd_rdy low the next cycle).
REQ-022 Read acceptance (rd_req && rd_rdy, no write): latch rd_addr, arsize={1'b0,rd_size}; next state R_AR.
REQ-023 R_AR: arvalid=1, araddr/arsize stable until arready; on arvalid&&arready -> R_R.
REQ-024 R_R: rready=1; on rvalid&&rlast capture rdata into ret_data -> R_RET; rresp ignored.
REQ-025 R_RET: ret_valid=1 for exactly one cycle -> R_IDLE; ret_data holds until the next capture.
REQ-026 Write acceptance: latch wr_addr, wr_data, wr_wstrb; awsize=3'd2; next state W_REQ.
REQ-027 W_REQ: awvalid and wvalid asserted together; each drops independently after its own handshake; state advances to W_B once both handshakes have completed (same or different cycles).
REQ-028 W_B: bready=1; on bvalid -> W_RET; bresp ignored. W_RET: wr_valid=1 one cycle -> W_IDLE.
REQ-029 Minimum latency with arready, rvalid, awready, wready, bvalid held high: read accept at cycle 0 -> arvalid cycle 1 -> R handshake cycle 2 -> ret_valid cycle 3; write identical.
REQ-030 No combinational path from any AXI input to any AXI output valid/ready.

Reset
REQ-031 resetn low: both FSMs to IDLE; arvalid, rready, awvalid, wvalid, bready, ret_valid, wr_valid = 0; ret_data, latched address/data/strobe = 0; rd_rdy = wr_rdy = 1 once resetn deasserts.
REQ-032 Reset mid-transaction aborts immediately, without waiting for AXI handshake completion; the system resets the interconnect together with the bridge.

Verification
REQ-033 Read, all ready high: rd_req, rd_addr=0xBFD0_F010, rd_size=2, rdata=0x1234_5678 -> arvalid cycle 1, araddr=0xBFD0_F010, arsize=2, arlen=0, ret_valid cycle 3, ret_data=0x1234_5678.
REQ-034 Write, awready delayed 3 cycles, wready immediate: wr_addr=0xBFAF_8000, wr_data=0xA5A5_0001, wstrb=4'b0011 -> wvalid drops after 1 cycle, awvalid held 3 cycles, single wr_valid pulse after bvalid.
REQ-035 Simultaneous rd_req and wr_req at idle -> write issued first; rd_rdy stays 0 until cycle after wr_valid; read then completes normally.
REQ-036 Byte read rd_size=0, arready stalled 5 cycles -> araddr/arsize stable throughout, arsize=0, exactly one ret_valid pulse.
REQ-037 resetn pulled low while in R_R -> arvalid/rready/ret_valid = 0 in the same cycle; after release rd_rdy=1 and a new read completes.

Source files
------------

// File: rtl/uncache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uncache_axi_bridge
// Purpose  : Turns single uncached read/write requests from the cache side
//            into single-beat AXI transactions. Only one transaction is in
//            flight at a time. When a read and a write arrive together, the
//            write is taken first.
// Ports    : clk, resetn (async, active-low)
//            Cache side : rd_req/rd_addr/rd_size -> rd_rdy, ret_valid, ret_data
//                         wr_req/wr_addr/wr_data/wr_wstrb -> wr_rdy, wr_valid
//            AXI master : AR, R, AW, W and B channels, single beat, INCR burst
// Revision : 1.0 - initial release
// ============================================================================
module uncache_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  // cache-side read
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic [1:0]  rd_size,
  output logic        rd_rdy,
  output logic        ret_valid,
  output logic [31:0] ret_data,
  // cache-side write
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_wstrb,
  output logic        wr_rdy,
  output logic        wr_valid,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2,
    R_RET  = 2'd3
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2,
    W_RET  = 2'd3
  } wr_state_e;

  rd_state_e   rd_state_q, rd_state_d;
  wr_state_e   wr_state_q, wr_state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rd_addr_q;
  logic [2:0]  arsize_q;
  logic [31:0] ret_data_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic [3:0]  wr_strb_q;

  logic both_idle;
  logic rd_accept;
  logic wr_accept;
  logic r_last_hs;
  logic aw_hs;
  logic w_hs;
  logic unused_resp;

  // Response codes are not reported back to the cache.
  assign unused_resp = ^{rresp, bresp};

  assign both_idle = (rd_state_q == R_IDLE) && (wr_state_q == W_IDLE);
  assign rd_rdy    = both_idle;
  assign wr_rdy    = both_idle;
  // A write wins when both requests are present in the same idle cycle.
  assign wr_accept = wr_req && both_idle;
  assign rd_accept = rd_req && both_idle && !wr_req;

  // All valid/ready outputs decode registered state only.
  assign arvalid   = (rd_state_q == R_AR);
  assign rready    = (rd_state_q == R_R);
  assign ret_valid = (rd_state_q == R_RET);
  assign awvalid   = (wr_state_q == W_REQ) && !aw_done_q;
  assign wvalid    = (wr_state_q == W_REQ) && !w_done_q;
  assign bready    = (wr_state_q == W_B);
  assign wr_valid  = (wr_state_q == W_RET);

  assign r_last_hs = rready && rvalid && rlast;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;

  assign arid      = AXI_ID;
  assign araddr    = rd_addr_q;
  assign arlen     = 8'd0;
  assign arsize    = arsize_q;
  assign arburst   = 2'b01;
  assign ret_data  = ret_data_q;
  assign awid      = AXI_ID;
  assign awaddr    = wr_addr_q;
  assign awlen     = 8'd0;
  assign awsize    = 3'd2;
  assign awburst   = 2'b01;
  assign wdata     = wr_data_q;
  assign wstrb     = wr_strb_q;
  assign wlast     = 1'b1;

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (rd_accept) rd_state_d = R_AR;
      R_AR:    if (arready)   rd_state_d = R_R;
      R_R:     if (r_last_hs) rd_state_d = R_RET;
      R_RET:   rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // AW and W complete independently; the done flags remember which one
  // has already handshaken so its valid can drop while the other waits.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (wr_state_q)
      W_IDLE:  if (wr_accept) wr_state_d = W_REQ;
      W_REQ: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          wr_state_d = W_B;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      W_B:     if (bvalid) wr_state_d = W_RET;
      W_RET:   wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_addr_q  <= 32'd0;
      arsize_q   <= 3'd0;
      ret_data_q <= 32'd0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
      wr_strb_q  <= 4'd0;
    end else begin
      if (rd_accept) begin
        rd_addr_q <= rd_addr;
        arsize_q  <= {1'b0, rd_size};
      end
      if (r_last_hs) begin
        ret_data_q <= rdata;
      end
      if (wr_accept) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
        wr_strb_q <= wr_wstrb;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uncache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uncache_axi_bridge
// Purpose  : Self-checking bench for uncache_axi_bridge. The bench plays the
//            cache and an AXI slave with configurable stalls, and predicts
//            per-transaction latency, valid durations and returned data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uncache_axi_bridge;

  localparam int TXN_CYCLES = 20;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rd_req, wr_req;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [1:0]  rd_size;
  logic [3:0]  wr_wstrb;
  logic        rd_rdy, ret_valid, wr_rdy, wr_valid;
  logic [31:0] ret_data;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uncache_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_wstrb(wr_wstrb),
    .wr_rdy(wr_rdy), .wr_valid(wr_valid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
    int          ar_dly;
    int          r_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
  } txn_t;

  typedef struct {
    txn_t t;
    int   exp_lat;
    int   exp_vc;
    int   exp_wvc;
  } vec_t;

  typedef struct {
    int          lat;
    int          pulses;
    logic [31:0] ret;
    int          vc;
    int          wvc;
    int          bad;
    bit          field_ok;
  } obs_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic txn_t mk(input bit is_wr, input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] data, input logic [3:0] strb,
                              input int ar, input int r, input int aw, input int w, input int b);
    txn_t t;
    t.is_wr = is_wr; t.addr = addr; t.size = size; t.data = data; t.strb = strb;
    t.ar_dly = ar; t.r_dly = r; t.aw_dly = aw; t.w_dly = w; t.b_dly = b;
    return t;
  endfunction

  // Reference model: every channel handshake costs one cycle plus whatever
  // stall the slave adds; AW and W overlap so only the slower one counts.
  function automatic int model_lat(input txn_t t);
    if (t.is_wr) return 3 + ((t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly) + t.b_dly;
    return 3 + t.ar_dly + t.r_dly;
  endfunction

  task automatic idle_axi();
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; rresp = 2'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
  endtask

  // Issues one request at a negedge and acts as the AXI slave for a fixed
  // window, recording what the bridge did.
  task automatic run_txn(input txn_t t, output obs_t o);
    int  avc, awc, wc, rwait, bwait;
    bit  r_phase, r_done, aw_done, w_done, b_phase, b_done, ar_now;
    o.lat = -1; o.pulses = 0; o.ret = 32'd0; o.vc = 0; o.wvc = 0; o.bad = 0; o.field_ok = 1'b1;
    avc = 0; awc = 0; wc = 0; rwait = 0; bwait = 0;
    r_phase = 0; r_done = 0; aw_done = 0; w_done = 0; b_phase = 0; b_done = 0;
    rd_req = !t.is_wr; wr_req = t.is_wr;
    rd_addr = t.addr; rd_size = t.size;
    wr_addr = t.addr; wr_data = t.data; wr_wstrb = t.strb;
    idle_axi();
    @(posedge clk); @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    for (int cyc = 1; cyc <= TXN_CYCLES; cyc++) begin
      if (t.is_wr ? wr_valid : ret_valid) begin
        o.pulses++;
        if (o.lat < 0) begin
          o.lat = cyc;
          o.ret = ret_data;
        end
      end
      if (t.is_wr ? (ret_valid | arvalid) : (wr_valid | awvalid | wvalid)) o.bad++;
      arready = 1'b0;
      if (arvalid) begin
        avc++;
        if (araddr !== t.addr || arsize !== {1'b0, t.size} || arlen !== 8'd0 ||
            arburst !== 2'b01 || arid !== 4'd1) o.field_ok = 1'b0;
        arready = (avc > t.ar_dly);
      end
      ar_now = arvalid && arready;
      rvalid = 1'b0;
      if (r_phase && !r_done) begin
        rvalid = (rwait >= t.r_dly);
        rwait++;
        if (rvalid && rready) r_done = 1'b1;
      end
      rdata = rvalid ? t.data : 32'hDEAD_BEEF;
      rlast = rvalid;
      if (ar_now) r_phase = 1'b1;
      awready = 1'b0;
      wready  = 1'b0;
      if (awvalid) begin
        awc++;
        if (awaddr !== t.addr || awsize !== 3'd2 || awlen !== 8'd0 ||
            awburst !== 2'b01 || awid !== 4'd1) o.field_ok = 1'b0;
        awready = (awc > t.aw_dly);
        if (awready) aw_done = 1'b1;
      end
      if (wvalid) begin
        wc++;
        if (wdata !== t.data || wstrb !== t.strb || wlast !== 1'b1) o.field_ok = 1'b0;
        wready = (wc > t.w_dly);
        if (wready) w_done = 1'b1;
      end
      bvalid = 1'b0;
      if (b_phase && !b_done) begin
        bvalid = (bwait >= t.b_dly);
        bwait++;
        if (bvalid && bready) b_done = 1'b1;
      end
      if (aw_done && w_done) b_phase = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    o.vc  = t.is_wr ? awc : avc;
    o.wvc = wc;
    idle_axi();
  endtask

  task automatic check_txn(input string nm, input txn_t t, input int exp_lat,
                           input int exp_vc, input int exp_wvc);
    obs_t o;
    run_txn(t, o);
    chk({nm, " latency"}, o.lat, exp_lat);
    chk({nm, " done pulses"}, o.pulses, 1);
    if (!t.is_wr) chk({nm, " ret_data"}, o.ret, t.data);
    chk({nm, " addr valid cycles"}, o.vc, exp_vc);
    chk({nm, " wvalid cycles"}, o.wvc, exp_wvc);
    chk({nm, " stray activity"}, o.bad, 0);
    chk({nm, " channel fields"}, {31'd0, o.field_ok}, 32'd1);
    chk({nm, " idle rdy"}, {30'd0, rd_rdy, wr_rdy}, 32'd3);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    txn_t rt;
    int   wv_at, rdy_at, rv_at;
    logic [31:0] rv_data;
    bit   drop, ar_early;

    vecs[0] = '{mk(1'b0, 32'hBFD0_F010, 2'd2, 32'h1234_5678, 4'h0, 0, 0, 0, 0, 0), 3, 1, 0};
    vecs[1] = '{mk(1'b1, 32'hBFAF_8000, 2'd2, 32'hA5A5_0001, 4'b0011, 0, 0, 2, 0, 0), 5, 3, 1};
    vecs[2] = '{mk(1'b0, 32'hBFD0_F003, 2'd0, 32'h0000_00AB, 4'h0, 5, 0, 0, 0, 0), 8, 6, 0};
    vecs[3] = '{mk(1'b1, 32'h1FC0_0004, 2'd2, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 4, 2), 9, 2, 5};
    vecs[4] = '{mk(1'b0, 32'h1FC0_0010, 2'd1, 32'h0BAD_F00D, 4'h0, 1, 4, 0, 0, 0), 8, 2, 0};

    resetn = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = 32'd0; rd_size = 2'd0; wr_addr = 32'd0; wr_data = 32'd0; wr_wstrb = 4'd0;
    idle_axi();
    repeat (3) @(negedge clk);
    chk("reset valids", {arvalid, rready, awvalid, wvalid, bready, ret_valid, wr_valid}, 32'd0);
    chk("reset ret_data", ret_data, 32'd0);
    chk("reset araddr", araddr, 32'd0);
    chk("reset awaddr", awaddr, 32'd0);
    chk("reset wdata", wdata, 32'd0);
    chk("reset wstrb", wstrb, 32'd0);
    chk("reset constants", {arlen, awlen, arburst, awburst, wlast}, {8'd0, 8'd0, 2'b01, 2'b01, 1'b1});
    resetn = 1'b1;
    @(negedge clk);
    chk("post reset rdy", {rd_rdy, wr_rdy}, 32'd3);

    for (int i = 0; i < 5; i++) begin
      check_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].exp_lat, vecs[i].exp_vc, vecs[i].exp_wvc);
    end

    for (int i = 0; i < 30; i++) begin
      rt = mk(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 2)), $urandom,
              4'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      check_txn($sformatf("rnd%0d", i), rt, model_lat(rt),
                (rt.is_wr ? rt.aw_dly : rt.ar_dly) + 1, rt.is_wr ? rt.w_dly + 1 : 0);
    end

    // Read and write together while idle: the write goes first.
    wv_at = -1; rdy_at = -1; rv_at = -1; rv_data = 32'd0; drop = 0; ar_early = 0;
    rd_req = 1'b1; wr_req = 1'b1; rd_addr = 32'h1FD0_0100; rd_size = 2'd2;
    wr_addr = 32'h1FD0_0200; wr_data = 32'h5555_AAAA; wr_wstrb = 4'hF;
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = 32'hCAFE_0042;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    wr_req = 1'b0;
    chk("simul write first", {awvalid, wvalid, arvalid, rd_rdy}, 32'b1100);
    for (int c = 1; c <= 12; c++) begin
      if (wr_valid && wv_at < 0) wv_at = c;
      if (rd_rdy && rdy_at < 0) rdy_at = c;
      if (ret_valid && rv_at < 0) begin
        rv_at = c;
        rv_data = ret_data;
      end
      if (arvalid && wv_at < 0) ar_early = 1'b1;
      if (drop) rd_req = 1'b0;
      if (rd_rdy && rd_req) drop = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    rd_req = 1'b0;
    idle_axi();
    chk("simul wr_valid cycle", wv_at, 3);
    chk("simul rd_rdy cycle", rdy_at, 4);
    chk("simul ret_valid cycle", rv_at, 7);
    chk("simul ret_data", rv_data, 32'hCAFE_0042);
    chk("simul no early read", {31'd0, ar_early}, 32'd0);

    // Reset while waiting for read data.
    rd_req = 1'b1; rd_addr = 32'hBFD0_0040; rd_size = 2'd2; arready = 1'b1;
    @(posedge clk); @(negedge clk);
    rd_req = 1'b0;
    chk("abort arvalid", arvalid, 1);
    @(posedge clk); @(negedge clk);
    arready = 1'b0;
    chk("abort in R_R", rready, 1);
    #2 resetn = 1'b0;
    #1 chk("abort outputs low", {arvalid, rready, ret_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("abort rd_rdy", rd_rdy, 1);
    check_txn("after abort", mk(1'b0, 32'hBFD0_0044, 2'd2, 32'h7777_1234, 4'h0, 1, 1, 0, 0, 0), 5, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
